sram_access_ctrl: RTL and testbench
===================================

Name: sram_access_ctrl

Overview:
Single-port SRAM timing controller between the multi-CPU memory arbiter and the board SRAM pins and tristate data buffer. It accepts one granted request at a time with a valid/ready handshake and sequences CE/OE/WE/UB/LB through setup, access and hold phases. It captures read data and returns a one-cycle done pulse to the arbiter. All outputs are registered.

Parameters:
ADDR_W, 20, SRAM address width.
DATA_W, 16, SRAM data width; 16 required, because byte lanes are fixed at 2.
WAIT_CYCLES, 2, strobe-active cycles per access; legal range 1..15.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  synchronous, active-high reset.
req_valid  in  1  arbiter has a granted request.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  word address.
req_wdata  in  DATA_W  write data.
req_be  in  2  byte enables: [1] = upper, [0] = lower; active high.
req_ready  out  1  controller can accept a request (IDLE only).
rsp_done  out  1  one-cycle pulse: access finished.
rsp_rdata  out  DATA_W  read data; valid while rsp_done is high, then held.
busy  out  1  high in any state other than IDLE.
SRAM_ADDR  out  ADDR_W  address pins.
SRAM_CE_N  out  1  chip enable, active low.
SRAM_OE_N  out  1  output enable, active low.
SRAM_WE_N  out  1  write enable, active low.
SRAM_UB_N  out  1  upper byte enable, active low.
SRAM_LB_N  out  1  lower byte enable, active low.
Data_write  out  DATA_W  data to the tristate buffer.
Data_read  in  DATA_W  data from the tristate buffer.
drive_en  out  1  tristate output enable; 1 = FPGA drives the bus.

Behaviour:
- Reset values (effective the cycle after a Reset edge):
  - State = IDLE.
  - SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N = 1.
  - drive_en = 0, rsp_done = 0, busy = 0, req_ready = 1.
  - SRAM_ADDR = 0, Data_write = 0, rsp_rdata = 0.
- Reset has priority over every other event.
- FSM states: IDLE, SETUP, ACCESS, HOLD. A wait counter of 4 bits drives ACCESS.
- IDLE:
  - req_ready = 1 and all strobes are deasserted.
  - When req_valid is high at a clock edge, latch addr, wdata, we and be, then go to SETUP.
  - Cycle numbering: the accept edge is cycle 0; cycle N is the Nth edge after it.
- SETUP (1 cycle, cycle 1):
  - SRAM_ADDR = latched address; CE_N = 0.
  - UB_N = ~be[1], LB_N = ~be[0].
  - OE_N = WE_N = 1.
  - For a write, drive_en = 1 and Data_write = wdata.
- ACCESS (WAIT_CYCLES cycles, cycles 2 .. 1+WAIT_CYCLES):
  - Read: OE_N = 0. Data_read is sampled into rsp_rdata on the last ACCESS cycle.
  - Bytes with be = 0 return 0 in rsp_rdata.
  - Write: WE_N = 0 and drive_en = 1.
- HOLD (1 cycle, cycle 2+WAIT_CYCLES):
  - OE_N = WE_N = 1; CE_N, address and byte enables are held.
  - For a write, drive_en = 1 and data is held (hold time).
  - Next state is IDLE.
- Completion (cycle 3+WAIT_CYCLES):
  - rsp_done = 1 for exactly one cycle, while in IDLE; req_ready = 1 in the same cycle.
  - A new request may be accepted on this cycle's edge, so back-to-back accesses are possible.
  - Throughput is one access per 3+WAIT_CYCLES cycles.
- drive_en is never 1 while OE_N = 0, in any cycle.
- req_valid while busy: ignored. No queuing; the arbiter must hold the request until req_ready.
- Request inputs are sampled only at the accept edge; later changes have no effect.
- rsp_rdata holds its last read value across writes and until the next read completes.
- Reset mid-operation:
  - Strobes deassert and drive_en = 0 the cycle after the Reset edge.
  - rsp_done is not pulsed and the in-flight request is discarded.
- WAIT_CYCLES = 1: ACCESS lasts exactly 1 cycle, and rsp_done arrives at cycle 4.

Test Plan:
1. Write, WAIT_CYCLES=2: addr=0x00010, wdata=0xBEEF, be=2'b11.
   - Cycle 1: CE_N=0, WE_N=1, drive_en=1.
   - Cycles 2-3: WE_N=0, Data_write=0xBEEF.
   - Cycle 4: WE_N=1, drive_en=1.
   - Cycle 5: rsp_done=1 for one cycle, drive_en=0.
2. Read, WAIT_CYCLES=2: addr=0x00010, SRAM model returns 0xBEEF.
   - Cycles 2-3: OE_N=0, drive_en=0.
   - Cycle 5: rsp_done=1, rsp_rdata=0xBEEF; value held afterwards.
3. Byte lanes: write be=2'b01, data 0x1234.
   - UB_N=1, LB_N=0 in cycles 1-4.
   - Then read with be=2'b10 where memory holds 0xAB34 -> rsp_rdata=0xAB00.
4. Back-to-back: req_valid held high continuously.
   - Second request is accepted on the same edge as the first rsp_done.
   - Exactly 5 cycles between the two rsp_done pulses.
   - No cycle has OE_N=0 together with drive_en=1.
5. Reset asserted in cycle 3 of a write.
   - Next cycle: all strobes=1, drive_en=0, req_ready=1.
   - No rsp_done; a new read then completes normally.
6. Parameter sweep WAIT_CYCLES=1 and 15.
   - rsp_done at cycle 4 and cycle 18 respectively.
   - Strobe-low width is 1 and 15 cycles respectively.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// SRAM timing controller: sequences CE/OE/WE/UB/LB for one
// granted access at a time, with setup, access and hold phases.
module sram_access_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              req_ready,
  output logic              rsp_done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [DATA_W-1:0] Data_write,
  input  logic [DATA_W-1:0] Data_read,
  output logic              drive_en
);

  localparam int HALF_W = DATA_W / 2;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [1:0]  be_q;
  logic [DATA_W-1:0] lane_mask;

  assign lane_mask = {{HALF_W{be_q[1]}}, {HALF_W{be_q[0]}}};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      we_q       <= 1'b0;
      be_q       <= 2'b00;
      req_ready  <= 1'b1;
      rsp_done   <= 1'b0;
      rsp_rdata  <= '0;
      busy       <= 1'b0;
      SRAM_ADDR  <= '0;
      SRAM_CE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_UB_N  <= 1'b1;
      SRAM_LB_N  <= 1'b1;
      Data_write <= '0;
      drive_en   <= 1'b0;
    end else begin
      rsp_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= SETUP;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            we_q      <= req_we;
            be_q      <= req_be;
            SRAM_ADDR <= req_addr;
            SRAM_CE_N <= 1'b0;
            SRAM_UB_N <= ~req_be[1];
            SRAM_LB_N <= ~req_be[0];
            if (req_we) begin
              drive_en   <= 1'b1;
              Data_write <= req_wdata;
            end
          end
        end
        SETUP: begin
          state    <= ACCESS;
          wait_cnt <= WAIT_LAST;
          if (we_q) begin
            SRAM_WE_N <= 1'b0;
          end else begin
            SRAM_OE_N <= 1'b0;
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state     <= HOLD;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            // Last strobe cycle: bus data is stable here
            if (!we_q) begin
              rsp_rdata <= Data_read & lane_mask;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        HOLD: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_done  <= 1'b1;
          SRAM_CE_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
          drive_en  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a small SRAM model
// and two extra instances at WAIT_CYCLES = 1 and 15.
module tb_sram_access_ctrl;

  int checks = 0;
  int errors = 0;
  int ovl = 0;

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [19:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = 2'b00;
  logic        req_ready, rsp_done, busy;
  logic [15:0] rsp_rdata;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
  logic        SRAM_UB_N, SRAM_LB_N;
  logic [15:0] Data_write, Data_read;
  logic        drive_en;

  logic        x_valid = 1'b0;
  logic        x_we = 1'b0;
  logic [19:0] x_addr = '0;
  logic [15:0] x_wdata = '0;
  logic [1:0]  x_be = 2'b11;
  logic [15:0] x_rd;
  logic        p1_rdy, p1_done, p1_busy;
  logic [15:0] p1_rdata, p1_dw;
  logic [19:0] p1_addr;
  logic        p1_ce, p1_oe, p1_we, p1_ub, p1_lb, p1_de;
  logic        p15_rdy, p15_done, p15_busy;
  logic [15:0] p15_rdata, p15_dw;
  logic [19:0] p15_addr;
  logic        p15_ce, p15_oe, p15_we, p15_ub, p15_lb, p15_de;

  logic [15:0] mem [0:255];

  always #5 Clk = ~Clk;

  assign x_rd = 16'hA5C3;

  sram_access_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .req_ready(req_ready),
    .rsp_done(rsp_done), .rsp_rdata(rsp_rdata),
    .busy(busy), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .Data_write(Data_write),
    .Data_read(Data_read), .drive_en(drive_en)
  );

  sram_access_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(1)) u1 (
    .Clk(Clk), .Reset(Reset),
    .req_valid(x_valid), .req_we(x_we),
    .req_addr(x_addr), .req_wdata(x_wdata),
    .req_be(x_be), .req_ready(p1_rdy),
    .rsp_done(p1_done), .rsp_rdata(p1_rdata),
    .busy(p1_busy), .SRAM_ADDR(p1_addr),
    .SRAM_CE_N(p1_ce), .SRAM_OE_N(p1_oe),
    .SRAM_WE_N(p1_we), .SRAM_UB_N(p1_ub),
    .SRAM_LB_N(p1_lb), .Data_write(p1_dw),
    .Data_read(x_rd), .drive_en(p1_de)
  );

  sram_access_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(15)) u15 (
    .Clk(Clk), .Reset(Reset),
    .req_valid(x_valid), .req_we(x_we),
    .req_addr(x_addr), .req_wdata(x_wdata),
    .req_be(x_be), .req_ready(p15_rdy),
    .rsp_done(p15_done), .rsp_rdata(p15_rdata),
    .busy(p15_busy), .SRAM_ADDR(p15_addr),
    .SRAM_CE_N(p15_ce), .SRAM_OE_N(p15_oe),
    .SRAM_WE_N(p15_we), .SRAM_UB_N(p15_ub),
    .SRAM_LB_N(p15_lb), .Data_write(p15_dw),
    .Data_read(x_rd), .drive_en(p15_de)
  );

  always @(posedge Clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_UB_N) mem[SRAM_ADDR[7:0]][15:8] <= Data_write[15:8];
      if (!SRAM_LB_N) mem[SRAM_ADDR[7:0]][7:0] <= Data_write[7:0];
    end
  end

  assign Data_read = (!SRAM_CE_N && !SRAM_OE_N) ?
                     mem[SRAM_ADDR[7:0]] : 16'h0000;

  always @(negedge Clk) begin
    if (!SRAM_OE_N && drive_en) ovl++;
    if (!p1_oe && p1_de) ovl++;
    if (!p15_oe && p15_de) ovl++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic xfer(input logic we, input logic [19:0] a,
                      input logic [15:0] d, input logic [1:0] be,
                      output int done_at);
    done_at = -1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    req_be = be;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (rsp_done) begin
        done_at = n;
        break;
      end
      tick();
    end
  endtask

  int dn, d1, d2, c15, c1, l1, l15;
  int spurious;

  initial begin
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_ready", req_ready === 1'b1);
    chk("rst_busy", busy === 1'b0);
    chk("rst_done", rsp_done === 1'b0);
    chk("rst_strobes",
        {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}
        === 5'b11111);
    chk("rst_drive", drive_en === 1'b0);
    chk("rst_addr", SRAM_ADDR === 20'h0);
    chk("rst_wdata", Data_write === 16'h0);
    chk("rst_rdata", rsp_rdata === 16'h0);

    req_we = 1'b1;
    req_addr = 20'h00010;
    req_wdata = 16'hBEEF;
    req_be = 2'b11;
    req_valid = 1'b1;
    tick();
    req_we = 1'b0;
    req_addr = 20'h00077;
    req_wdata = 16'h0000;
    req_be = 2'b00;
    chk("t1_c1_ce", SRAM_CE_N === 1'b0);
    chk("t1_c1_we", SRAM_WE_N === 1'b1);
    chk("t1_c1_oe", SRAM_OE_N === 1'b1);
    chk("t1_c1_drive", drive_en === 1'b1);
    chk("t1_c1_addr", SRAM_ADDR === 20'h00010);
    chk("t1_c1_ready", req_ready === 1'b0);
    chk("t1_c1_busy", busy === 1'b1);
    tick();
    chk("t1_c2_we", SRAM_WE_N === 1'b0);
    chk("t1_c2_data", Data_write === 16'hBEEF);
    chk("t1_c2_drive", drive_en === 1'b1);
    tick();
    chk("t1_c3_we", SRAM_WE_N === 1'b0);
    chk("t1_c3_addr", SRAM_ADDR === 20'h00010);
    req_valid = 1'b0;
    tick();
    chk("t1_c4_we", SRAM_WE_N === 1'b1);
    chk("t1_c4_drive", drive_en === 1'b1);
    chk("t1_c4_ce", SRAM_CE_N === 1'b0);
    chk("t1_c4_data", Data_write === 16'hBEEF);
    chk("t1_c4_done", rsp_done === 1'b0);
    tick();
    chk("t1_c5_done", rsp_done === 1'b1);
    chk("t1_c5_drive", drive_en === 1'b0);
    chk("t1_c5_ready", req_ready === 1'b1);
    chk("t1_c5_ce", SRAM_CE_N === 1'b1);
    tick();
    chk("t1_c6_done", rsp_done === 1'b0);
    chk("t1_c6_busy", busy === 1'b0);
    chk("t1_mem", mem[16] === 16'hBEEF);

    req_we = 1'b0;
    req_addr = 20'h00010;
    req_be = 2'b11;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_addr = 20'h00033;
    chk("t2_c1_oe", SRAM_OE_N === 1'b1);
    chk("t2_c1_drive", drive_en === 1'b0);
    tick();
    chk("t2_c2_oe", SRAM_OE_N === 1'b0);
    chk("t2_c2_drive", drive_en === 1'b0);
    tick();
    chk("t2_c3_oe", SRAM_OE_N === 1'b0);
    chk("t2_c3_drive", drive_en === 1'b0);
    tick();
    chk("t2_c4_oe", SRAM_OE_N === 1'b1);
    tick();
    chk("t2_c5_done", rsp_done === 1'b1);
    chk("t2_c5_rdata", rsp_rdata === 16'hBEEF);
    tick();
    tick();
    chk("t2_held", rsp_rdata === 16'hBEEF);

    xfer(1'b1, 20'h00020, 16'hABFF, 2'b11, dn);
    chk("t3_pre_done", dn === 5);
    tick();
    req_we = 1'b1;
    req_addr = 20'h00020;
    req_wdata = 16'h1234;
    req_be = 2'b01;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("t3_ub", SRAM_UB_N === 1'b1);
      chk("t3_lb", SRAM_LB_N === 1'b0);
      tick();
    end
    chk("t3_w_done", rsp_done === 1'b1);
    chk("t3_lanes_off", {SRAM_UB_N, SRAM_LB_N} === 2'b11);
    chk("t3_mem", mem[32] === 16'hAB34);
    chk("t3_rdata_held", rsp_rdata === 16'hBEEF);
    tick();
    xfer(1'b0, 20'h00020, 16'h0000, 2'b10, dn);
    chk("t3_r_done", dn === 5);
    chk("t3_rdata", rsp_rdata === 16'hAB00);
    tick();

    d1 = -1;
    d2 = -1;
    req_we = 1'b1;
    req_addr = 20'h00030;
    req_wdata = 16'hC0DE;
    req_be = 2'b11;
    req_valid = 1'b1;
    tick();
    req_we = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (rsp_done && d1 < 0) d1 = n;
      else if (rsp_done && d2 < 0) d2 = n;
      if (n == 6) begin
        chk("t4_accepted", busy === 1'b1);
        chk("t4_c6_ce", SRAM_CE_N === 1'b0);
        chk("t4_c6_drive", drive_en === 1'b0);
        req_valid = 1'b0;
      end
      if (d2 > 0) break;
      tick();
    end
    chk("t4_d1", d1 === 5);
    chk("t4_d2", d2 === 10);
    chk("t4_rdata", rsp_rdata === 16'hC0DE);
    tick();

    req_we = 1'b1;
    req_addr = 20'h00040;
    req_wdata = 16'h5555;
    req_be = 2'b11;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("t5_strobes",
        {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}
        === 5'b11111);
    chk("t5_drive", drive_en === 1'b0);
    chk("t5_ready", req_ready === 1'b1);
    chk("t5_busy", busy === 1'b0);
    spurious = 0;
    for (int n = 0; n < 6; n++) begin
      if (rsp_done) spurious++;
      tick();
    end
    chk("t5_no_done", spurious === 0);
    xfer(1'b0, 20'h00010, 16'h0000, 2'b11, dn);
    chk("t5_r_done", dn === 5);
    chk("t5_rdata", rsp_rdata === 16'hBEEF);
    tick();

    for (int k = 0; k < 2; k++) begin
      c1 = -1;
      c15 = -1;
      l1 = 0;
      l15 = 0;
      x_we = (k == 1);
      x_addr = 20'h00005;
      x_wdata = 16'h0F0F;
      x_be = 2'b11;
      x_valid = 1'b1;
      tick();
      x_valid = 1'b0;
      for (int n = 1; n <= 25; n++) begin
        if (!p1_oe || !p1_we) l1++;
        if (!p15_oe || !p15_we) l15++;
        if (p1_done && c1 < 0) c1 = n;
        if (p15_done && c15 < 0) c15 = n;
        tick();
      end
      chk("t6_done_w1", c1 === 4);
      chk("t6_done_w15", c15 === 18);
      chk("t6_width_w1", l1 === 1);
      chk("t6_width_w15", l15 === 15);
      chk("t6_rdata_w1", p1_rdata === 16'hA5C3);
      chk("t6_rdata_w15", p15_rdata === 16'hA5C3);
    end

    chk("oe_drive_overlap", ovl === 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
